// File: rtl/hub75_fb_arbiter_if.sv
// Display/host/RAM bundle for the HUB75 framebuffer arbiter.
// Purely wiring; all timing is owned by the arbiter.
interface hub75_fb_arbiter_if #(
    parameter int aw_p      = 12,
    parameter int data_wd_p = 24
);
    logic                 i_rd_req;
    logic [aw_p-1:0]      i_rd_addr;
    logic                 o_rd_gnt;
    logic                 o_rd_valid;
    logic [data_wd_p-1:0] o_rd_data;
    logic                 i_wr_req;
    logic [aw_p-1:0]      i_wr_addr;
    logic [data_wd_p-1:0] i_wr_data;
    logic                 o_wr_gnt;
    logic                 i_swap_req;
    logic                 i_new_frame;
    logic                 o_swap_pending;
    logic                 o_swap_done;
    logic                 o_mem_en;
    logic                 o_mem_we;
    logic [aw_p:0]        o_mem_addr;
    logic [data_wd_p-1:0] o_mem_wdata;
    logic [data_wd_p-1:0] i_mem_rdata;

    modport master (
        output i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_data,
               i_swap_req, i_new_frame, i_mem_rdata,
        input  o_rd_gnt, o_rd_valid, o_rd_data, o_wr_gnt, o_swap_pending,
               o_swap_done, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
    );

    modport slave (
        input  i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_data,
               i_swap_req, i_new_frame, i_mem_rdata,
        output o_rd_gnt, o_rd_valid, o_rd_data, o_wr_gnt, o_swap_pending,
               o_swap_done, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
    );
endinterface

// File: rtl/hub75_fb_arbiter.sv
// Double-buffered framebuffer arbiter: display reads front bank, host writes back bank, one shared single-port RAM.
// Latency: grants and RAM controls combinational; o_rd_valid/o_rd_data one cycle after o_rd_gnt; swap lands one cycle after i_new_frame.
// Backpressure: reads win, writes forced through after starve_max_p denials, writes blocked while a swap is pending. Optional HUB75_FB_ARB_STATS_EN adds o_conflict_cnt.
module hub75_fb_arbiter #(
    parameter int hpixel_p     = 64,
    parameter int vpixel_p     = 64,
    parameter int data_wd_p    = 24,
    parameter int starve_max_p = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    hub75_fb_arbiter_if.slave bus
`ifdef HUB75_FB_ARB_STATS_EN
    ,
    output logic [15:0]       o_conflict_cnt
`endif
);
    localparam int aw = $clog2(hpixel_p*vpixel_p);
    localparam int sw = $clog2(starve_max_p+1);
    localparam logic [sw-1:0] starve_max_c = sw'(starve_max_p);

    typedef enum logic {ST_IDLE, ST_PENDING} swap_st_t;

    swap_st_t             state_q, state_d;
    logic                 front_bank_q, front_bank_d;
    logic                 swap_done_q, swap_done_d;
    logic [sw-1:0]        starve_cnt_q, starve_cnt_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [data_wd_p-1:0] rd_data_q, rd_data_d;
    logic [aw:0]          mem_addr_q, mem_addr_d;
    logic [data_wd_p-1:0] mem_wdata_q, mem_wdata_d;
    logic                 wr_blocked, starved, rd_gnt, wr_gnt;

    always_comb begin
        wr_blocked = (state_q == ST_PENDING);
        starved    = (starve_cnt_q == starve_max_c) && bus.i_wr_req && !wr_blocked;
        rd_gnt     = rst_n && bus.i_rd_req && !starved;
        wr_gnt     = rst_n && bus.i_wr_req && !wr_blocked && (starved || !bus.i_rd_req);

        // Address/data are held between accesses so the RAM pins stay quiet.
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (rd_gnt) begin
            mem_addr_d = {front_bank_q, bus.i_rd_addr};
        end else if (wr_gnt) begin
            mem_addr_d  = {~front_bank_q, bus.i_wr_addr};
            mem_wdata_d = bus.i_wr_data;
        end

        starve_cnt_d = starve_cnt_q;
        if (!wr_blocked) begin
            if (!bus.i_wr_req || wr_gnt) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != starve_max_c) begin
                starve_cnt_d = starve_cnt_q + sw'(1);
            end
        end

        rd_valid_d = rd_gnt;
        rd_data_d  = rd_valid_q ? bus.i_mem_rdata : rd_data_q;
    end

    always_comb begin
        state_d      = state_q;
        front_bank_d = front_bank_q;
        swap_done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A coincident frame boundary is deliberately not used to swap immediately.
                if (bus.i_swap_req) state_d = ST_PENDING;
            end
            ST_PENDING: begin
                if (bus.i_new_frame) begin
                    state_d      = ST_IDLE;
                    front_bank_d = ~front_bank_q;
                    swap_done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            front_bank_q <= 1'b0;
            swap_done_q  <= 1'b0;
            starve_cnt_q <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            front_bank_q <= front_bank_d;
            swap_done_q  <= swap_done_d;
            starve_cnt_q <= starve_cnt_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.o_rd_gnt       = rd_gnt;
    assign bus.o_wr_gnt       = wr_gnt;
    assign bus.o_rd_valid     = rd_valid_q;
    assign bus.o_rd_data      = rd_data_d;
    assign bus.o_mem_en       = rd_gnt || wr_gnt;
    assign bus.o_mem_we       = wr_gnt;
    assign bus.o_mem_addr     = mem_addr_d;
    assign bus.o_mem_wdata    = mem_wdata_d;
    assign bus.o_swap_pending = (state_q == ST_PENDING);
    assign bus.o_swap_done    = swap_done_q;

`ifdef HUB75_FB_ARB_STATS_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (bus.i_rd_req && bus.i_wr_req && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) conflict_cnt_q <= '0;
        else        conflict_cnt_q <= conflict_cnt_d;
    end

    assign o_conflict_cnt = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_hub75_fb_arbiter.sv
// Bench for hub75_fb_arbiter: directed stimulus, read-data scoreboard drained by a monitor,
// plus inline checks on the combinational grant/RAM outputs.
module tb_hub75_fb_arbiter;
    localparam int AW = 12;
    localparam int DW = 24;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hub75_fb_arbiter_if #(.aw_p(AW), .data_wd_p(DW)) bus_if ();

`ifdef HUB75_FB_ARB_STATS_EN
    logic [15:0] conflict_cnt;
`endif

    hub75_fb_arbiter #(
        .hpixel_p(64), .vpixel_p(64), .data_wd_p(DW), .starve_max_p(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus_if)
`ifdef HUB75_FB_ARB_STATS_EN
        ,
        .o_conflict_cnt(conflict_cnt)
`endif
    );

    // RAM model: every word preset to 0x100000 | {bank, addr}
    logic [DW-1:0] mem [0:(1<<(AW+1))-1];
    initial begin
        for (int i = 0; i < (1<<(AW+1)); i++) mem[i] = 24'h100000 | DW'(i);
    end
    always @(posedge clk) begin
        if (bus_if.o_mem_en) begin
            if (bus_if.o_mem_we) mem[bus_if.o_mem_addr] <= bus_if.o_mem_wdata;
            else                 bus_if.i_mem_rdata   <= mem[bus_if.o_mem_addr];
        end
    end

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rd, input logic [AW-1:0] ra, input logic wr,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic sw, input logic nf);
        @(posedge clk);
        #1;
        bus_if.i_rd_req    = rd;
        bus_if.i_rd_addr   = ra;
        bus_if.i_wr_req    = wr;
        bus_if.i_wr_addr   = wa;
        bus_if.i_wr_data   = wd;
        bus_if.i_swap_req  = sw;
        bus_if.i_new_frame = nf;
        #1;
    endtask

    // Monitor: every read-valid pops one expected word
    always @(negedge clk) begin
        if (rst_n && bus_if.o_rd_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: got valid data %0h expected none", bus_if.o_rd_data);
            end else begin
                chk("rd_data", 32'(bus_if.o_rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_w;
        rst_n              = 1'b0;
        bus_if.i_rd_req    = 1'b1;
        bus_if.i_rd_addr   = '0;
        bus_if.i_wr_req    = 1'b1;
        bus_if.i_wr_addr   = '0;
        bus_if.i_wr_data   = '0;
        bus_if.i_swap_req  = 1'b0;
        bus_if.i_new_frame = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        chk("rst_rd_gnt",   32'(bus_if.o_rd_gnt), 32'd0);
        chk("rst_wr_gnt",   32'(bus_if.o_wr_gnt), 32'd0);
        chk("rst_mem_en",   32'(bus_if.o_mem_en), 32'd0);
        chk("rst_rd_valid", 32'(bus_if.o_rd_valid), 32'd0);
        chk("rst_rd_data",  32'(bus_if.o_rd_data), 32'd0);
        chk("rst_pending",  32'(bus_if.o_swap_pending), 32'd0);
        chk("rst_done",     32'(bus_if.o_swap_done), 32'd0);
        chk("rst_mem_addr", 32'(bus_if.o_mem_addr), 32'd0);
        chk("rst_wdata",    32'(bus_if.o_mem_wdata), 32'd0);
`ifdef HUB75_FB_ARB_STATS_EN
        chk("rst_conflict", 32'(conflict_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n           = 1'b1;
        bus_if.i_rd_req = 1'b0;
        bus_if.i_wr_req = 1'b0;

        // Reads 0..3 from the front bank, back-to-back
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, AW'(i), 1'b0, '0, '0, 1'b0, 1'b0);
            chk("rd_gnt",   32'(bus_if.o_rd_gnt), 32'd1);
            chk("rd_wrgnt", 32'(bus_if.o_wr_gnt), 32'd0);
            chk("rd_en_we", 32'({bus_if.o_mem_en, bus_if.o_mem_we}), 32'b10);
            chk("rd_addr",  32'(bus_if.o_mem_addr), 32'(i));
            if (i > 0) chk("rd_b2b_valid", 32'(bus_if.o_rd_valid), 32'd1);
            exp_q.push_back(24'h100000 + DW'(i));
        end
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("idle_en",        32'(bus_if.o_mem_en), 32'd0);
        chk("idle_addr_hold", 32'(bus_if.o_mem_addr), 32'd3);
        chk("last_valid",     32'(bus_if.o_rd_valid), 32'd1);
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("valid_drop",     32'(bus_if.o_rd_valid), 32'd0);

        // Starvation: write forced through every 9th cycle
        for (int c = 0; c < 18; c++) begin
            drive(1'b1, AW'(7), 1'b1, AW'(9), 24'h123456, 1'b0, 1'b0);
            exp_w = ((c % 9) == 8);
            chk("starve_wr_gnt", 32'(bus_if.o_wr_gnt), 32'(exp_w));
            chk("starve_rd_gnt", 32'(bus_if.o_rd_gnt), 32'(!exp_w));
            chk("starve_we",     32'(bus_if.o_mem_we), 32'(exp_w));
            if (!exp_w) exp_q.push_back(24'h100007);
            else chk("starve_addr", 32'(bus_if.o_mem_addr), 32'h1009);
        end
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
`ifdef HUB75_FB_ARB_STATS_EN
        chk("conflict_cnt", 32'(conflict_cnt), 32'd18);
`endif

        // Host write to the back bank
        drive(1'b0, '0, 1'b1, AW'(5), 24'hABCDEF, 1'b0, 1'b0);
        chk("wr_gnt",   32'(bus_if.o_wr_gnt), 32'd1);
        chk("wr_en_we", 32'({bus_if.o_mem_en, bus_if.o_mem_we}), 32'b11);
        chk("wr_addr",  32'(bus_if.o_mem_addr), 32'h1005);
        chk("wr_data",  32'(bus_if.o_mem_wdata), 32'hABCDEF);
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("wdata_hold", 32'(bus_if.o_mem_wdata), 32'hABCDEF);

        // Swap with writes held off while pending
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("swreq_pending", 32'(bus_if.o_swap_pending), 32'd0);
        for (int k = 1; k < 10; k++) begin
            drive(1'b0, '0, 1'b1, AW'(5), 24'h111111, 1'b0, 1'b0);
            chk("pend_pending", 32'(bus_if.o_swap_pending), 32'd1);
            chk("pend_wr_gnt",  32'(bus_if.o_wr_gnt), 32'd0);
            chk("pend_mem_en",  32'(bus_if.o_mem_en), 32'd0);
        end
        drive(1'b1, AW'(5), 1'b1, AW'(5), 24'h111111, 1'b0, 1'b1);
        chk("nf_pending",   32'(bus_if.o_swap_pending), 32'd1);
        chk("nf_rd_gnt",    32'(bus_if.o_rd_gnt), 32'd1);
        chk("nf_wr_gnt",    32'(bus_if.o_wr_gnt), 32'd0);
        chk("nf_old_bank",  32'(bus_if.o_mem_addr), 32'h0005);
        chk("nf_done",      32'(bus_if.o_swap_done), 32'd0);
        exp_q.push_back(24'h100005);
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("swap_done",    32'(bus_if.o_swap_done), 32'd1);
        chk("swap_pend_lo", 32'(bus_if.o_swap_pending), 32'd0);
        drive(1'b1, AW'(5), 1'b0, '0, '0, 1'b0, 1'b0);
        chk("done_pulse",   32'(bus_if.o_swap_done), 32'd0);
        chk("new_front",    32'(bus_if.o_mem_addr), 32'h1005);
        exp_q.push_back(24'hABCDEF);

        // Coincident swap request and frame boundary: arm only
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1);
        chk("coinc_pend_now", 32'(bus_if.o_swap_pending), 32'd0);
        drive(1'b1, AW'(0), 1'b0, '0, '0, 1'b0, 1'b0);
        chk("coinc_pending",  32'(bus_if.o_swap_pending), 32'd1);
        chk("coinc_no_done",  32'(bus_if.o_swap_done), 32'd0);
        chk("coinc_bank",     32'(bus_if.o_mem_addr), 32'h1000);
        exp_q.push_back(24'h101000);
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("coinc_still_pend", 32'(bus_if.o_swap_pending), 32'd1);

        // Reset while pending abandons the swap
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_pending", 32'(bus_if.o_swap_pending), 32'd0);
        chk("mrst_done",    32'(bus_if.o_swap_done), 32'd0);
        chk("mrst_addr",    32'(bus_if.o_mem_addr), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
        chk("idle_nf_pend", 32'(bus_if.o_swap_pending), 32'd0);
        chk("mrst_no_done", 32'(bus_if.o_swap_done), 32'd0);
        drive(1'b1, AW'(0), 1'b0, '0, '0, 1'b0, 1'b0);
        chk("idle_nf_done", 32'(bus_if.o_swap_done), 32'd0);
        chk("mrst_bank0",   32'(bus_if.o_mem_addr), 32'h0000);
        exp_q.push_back(24'h100000);
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);

        for (int w = 0; w < 5 && exp_q.size() != 0; w++) @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hub75_fb_arbiter.md
HUB75_FB_ARBITER -- requirements
Module: hub75_fb_arbiter

Interface
REQ-001 SHALL have parameters: hpixel_p, default 64, display width; vpixel_p, default 64, display height; data_wd_p, default 24, RGB word width; starve_max_p, default 8, maximum consecutive denied write-request cycles; aw = $clog2(hpixel_p*vpixel_p), localparam.
REQ-002 SHALL have ports:
  clk  in  1  rising-edge clock;
  rst_n  in  1  asynchronous, active-low reset;
  i_rd_req  in  1  display read request;
  i_rd_addr  in  aw  display pixel address;
  o_rd_gnt  out  1  read granted this cycle;
  o_rd_valid  out  1  o_rd_data valid;
  o_rd_data  out  data_wd_p  read pixel;
  i_wr_req  in  1  host write request;
  i_wr_addr  in  aw  host pixel address;
  i_wr_data  in  data_wd_p  host pixel;
  o_wr_gnt  out  1  write granted this cycle;
  i_swap_req  in  1  host buffer-swap request pulse;
  i_new_frame  in  1  frame-boundary pulse from the display controller;
  o_swap_pending  out  1  swap armed, awaiting frame boundary;
  o_swap_done  out  1  one-cycle pulse on bank swap;
  o_mem_en  out  1  RAM enable;
  o_mem_we  out  1  RAM write enable;
  o_mem_addr  out  aw+1  {bank, pixel address};
  o_mem_wdata  out  data_wd_p  RAM write data;
  i_mem_rdata  in  data_wd_p  RAM read data, 1-cycle latency.

Function
REQ-003 SHALL share one single-port RAM holding two frame banks; reads target the front bank (front_bank), writes target the back bank (~front_bank).
REQ-004 SHALL compute grants and o_mem_* combinationally in the request cycle; at most one grant per cycle.
REQ-005 SHALL grant reads over writes, except when starve_cnt == starve_max_p and i_wr_req is high and writes are not blocked; then o_wr_gnt SHALL be set and o_rd_gnt SHALL be clear for that cycle.
REQ-006 SHALL increment starve_cnt (saturating at starve_max_p) each cycle i_wr_req is high, o_wr_gnt is low and writes are unblocked; SHALL clear it on o_wr_gnt or when i_wr_req is low.
REQ-007 SHALL assert o_rd_valid exactly 1 cycle after o_rd_gnt, with o_rd_data = i_mem_rdata in that cycle; back-to-back grants SHALL give back-to-back valids.
REQ-008 SHALL drive o_mem_en=0, o_mem_we=0, and hold o_mem_addr and o_mem_wdata at their previous values when no grant occurs.
REQ-009 Swap FSM states SHALL be IDLE and PENDING: IDLE->PENDING on i_swap_req; PENDING->IDLE on i_new_frame, with front_bank toggled and o_swap_done pulsed in the following cycle.
REQ-010 SHALL block writes (o_wr_gnt=0, starve_cnt held) while in PENDING, freezing the back bank until the swap.
REQ-011 Simultaneous i_swap_req and i_new_frame in IDLE SHALL only enter PENDING; the swap SHALL occur on the next i_new_frame.
REQ-012 i_swap_req while in PENDING SHALL be ignored; i_new_frame while in IDLE SHALL have no effect.
REQ-013 o_swap_pending SHALL be 1 exactly while in PENDING.
REQ-014 A read granted in the same cycle the bank toggles SHALL use the pre-toggle front bank.

Reset
REQ-015 On rst_n low, the block SHALL asynchronously set front_bank=0, FSM=IDLE, starve_cnt=0, o_rd_valid=0, o_rd_data=0, o_swap_done=0, o_mem_addr=0 and o_mem_wdata=0; grant outputs SHALL be 0 while rst_n is low.
REQ-016 Reset asserted mid-PENDING SHALL abandon the swap, with no o_swap_done.

Configuration
REQ-017 With HUB75_FB_ARB_STATS_EN defined, the block SHALL add output o_conflict_cnt[15:0], a saturating count of cycles with i_rd_req and i_wr_req both high (reset 0); without the macro, the port and its logic SHALL be absent and the arbitration behaviour SHALL be unchanged.

Verification
REQ-018 Reads only: i_rd_req high at addresses 0..3 for 4 cycles -> o_rd_gnt=1 each cycle, o_mem_addr={0,addr}, o_rd_valid 1 cycle later per read.
REQ-019 Starvation: i_rd_req and i_wr_req held high with starve_max_p=8 -> writes are denied for 8 cycles, granted on the 9th cycle, then the pattern repeats; with the stats macro defined, o_conflict_cnt=18 after 18 cycles.
REQ-020 Swap: write 0xABCDEF at address 5, pulse i_swap_req, then i_new_frame 10 cycles later -> o_swap_pending high for 10 cycles, o_swap_done one cycle after i_new_frame, and a subsequent read of address 5 returns 0xABCDEF with o_mem_addr[aw]=1.
REQ-021 Write blocking: i_wr_req high during PENDING with i_rd_req low -> o_wr_gnt=0 and o_mem_en=0 until the swap completes.
REQ-022 Corner cases: i_swap_req and i_new_frame asserted in the same cycle -> no swap on that cycle and o_swap_pending=1; reset asserted during PENDING -> front_bank=0 and no o_swap_done.
